// File: rtl/adc_spi_sampler.sv
// ---------------------------------------------------------------------------
// adc_spi_sampler
//
// SPI master and sample buffer for an 8-channel serial ADC. It runs single or
// free-running conversion frames. Each result is tagged with its channel and
// queued in a show-ahead FIFO. A consumer drains the FIFO with a valid/ready
// handshake.
//
// Ports (all logic on the rising edge of CLOCK_50, synchronous active-low
// reset RESET_N):
//   start        in   one-cycle request for a single frame on `channel`
//   auto_en      in   free-running scan, channels 0..7 in turn
//   channel      in   channel used by `start`
//   ovf_clr      in   clears the sticky overflow flag
//   SPI_MISO     in   ADC serial data
//   SPI_MOSI     out  control word to the ADC
//   SPI_CLOCK    out  serial clock, idle high
//   SPI_SS       out  chip select, active low
//   sample_data  out  FIFO head result
//   sample_chan  out  FIFO head channel tag
//   sample_valid out  FIFO not empty
//   sample_ready in   consumer pop
//   fifo_count   out  FIFO occupancy
//   busy         out  frame or inter-frame gap in progress
//   overflow     out  sticky: a sample was dropped because the FIFO was full
//
// Every output is a register. The SPI pins and `busy` are decoded from the
// state of the previous cycle. They therefore lag the FSM by one clock. For
// example, SPI_SS falls one edge after `start` is accepted.
// ---------------------------------------------------------------------------
module adc_spi_sampler #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          start,
    input  logic                          auto_en,
    input  logic [2:0]                    channel,
    input  logic                          ovf_clr,
    input  logic                          SPI_MISO,
    output logic                          SPI_MOSI,
    output logic                          SPI_CLOCK,
    output logic                          SPI_SS,
    output logic [DATA_BITS-1:0]          sample_data,
    output logic [2:0]                    sample_chan,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow
);

    localparam int CW   = $clog2(2 * CLK_DIV);   // cycle-in-phase counter
    localparam int BW   = $clog2(FRAME_BITS);    // bit-in-frame counter
    localparam int AW   = $clog2(FIFO_DEPTH);    // FIFO pointer
    localparam int CNTW = AW + 1;                // FIFO occupancy
    localparam int EW   = DATA_BITS + 3;         // FIFO entry: {chan, data}

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // -----------------------------------------------------------------------
    // Frame sequencer
    // -----------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_phase_end;
    logic                    w_accept;
    logic [CW-1:0]           r_cnt;
    logic [BW-1:0]           r_bit;
    logic [BW-1:0]           w_mosi_idx;
    logic [2:0]              r_chan;
    logic [2:0]              r_auto_chan;
    logic [DATA_BITS-1:0]    r_shift;
    logic [FRAME_BITS-1:0]   w_ctrl;
    logic                    r_ss;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_busy;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_phase_end  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start || auto_en) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(CLK_DIV - 1)) begin
                    w_phase_end  = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(2 * CLK_DIV - 1) && r_bit == BW'(FRAME_BITS - 1)) begin
                    w_phase_end  = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(CLK_DIV - 1)) begin
                    w_phase_end  = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(CLK_DIV - 1)) begin
                    w_phase_end  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The control word carries the channel in bits 13:11. All other bits are
    // zero.
    always_comb begin
        w_ctrl        = '0;
        w_ctrl[13:11] = r_chan;
    end

    // Bit r_bit of the frame transmits control bit FRAME_BITS-1-r_bit.
    assign w_mosi_idx = BW'(FRAME_BITS - 1) - r_bit;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register in the block then samples pre-edge values, whatever the
    // statement order.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_chan      <= '0;
            r_auto_chan <= '0;
            r_shift     <= '0;
            r_ss        <= 1'b1;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Phase timing. SHIFT reuses r_cnt as a 2*CLK_DIV bit period:
            // the first half is SCLK low and the second half is SCLK high.
            if (r_state == S_IDLE || w_phase_end) begin
                r_cnt <= '0;
                r_bit <= '0;
            end else if (r_state == S_SHIFT && r_cnt == CW'(2 * CLK_DIV - 1)) begin
                r_cnt <= '0;
                r_bit <= r_bit + BW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // An explicit start takes priority over the auto scan. The auto
            // channel only advances for frames the scan itself launches.
            if (w_accept) begin
                if (start) begin
                    r_chan <= channel;
                end else begin
                    r_chan      <= r_auto_chan;
                    r_auto_chan <= r_auto_chan + 3'd1;
                end
            end

            // MISO is captured on the same edge that raises SCLK. Only the
            // last DATA_BITS bits are kept.
            if (r_state == S_SHIFT && r_cnt == CW'(CLK_DIV)) begin
                r_shift <= {r_shift[DATA_BITS-2:0], SPI_MISO};
            end

            r_busy <= (r_state != S_IDLE);
            r_ss   <= !(r_state == S_SETUP || r_state == S_SHIFT || r_state == S_HOLD);
            r_sclk <= (r_state == S_SHIFT) ? (r_cnt >= CW'(CLK_DIV)) : 1'b1;

            case (r_state)
                S_SETUP: r_mosi <= w_ctrl[FRAME_BITS-1];
                S_SHIFT: begin
                    // Changes only on SCLK falling edges. On bit 0 this
                    // re-drives the bit already presented in SETUP.
                    if (r_cnt == '0) begin
                        r_mosi <= w_ctrl[w_mosi_idx];
                    end
                end
                S_HOLD:  r_mosi <= r_mosi;
                default: r_mosi <= 1'b0;
            endcase
        end
    end

    assign SPI_SS    = r_ss;
    assign SPI_CLOCK = r_sclk;
    assign SPI_MOSI  = r_mosi;
    assign busy      = r_busy;

    // -----------------------------------------------------------------------
    // Sample FIFO (show-ahead, registered head)
    // -----------------------------------------------------------------------
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_next;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] w_count_next;
    logic            r_valid;
    logic [EW-1:0]   r_head;
    logic [EW-1:0]   w_head_next;
    logic [EW-1:0]   w_push_word;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_do_push;
    logic            w_drop;

    // The result is pushed on the first GAP cycle. That is the same edge on
    // which SPI_SS returns high.
    assign w_push      = (r_state == S_GAP) && (r_cnt == '0);
    assign w_push_word = {r_chan, r_shift};
    assign w_pop       = r_valid && sample_ready;
    assign w_full      = (r_count == CNTW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot that a push into a full FIFO
    // needs.
    assign w_do_push   = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_rd_next   = r_rd_ptr + AW'(1);
    assign w_count_next = r_count + CNTW'(w_do_push) - CNTW'(w_pop);

    // Next head. After a pop the new head is the next stored entry. If only
    // one entry was stored, the new head is the word being pushed in the same
    // cycle, because that word has not reached r_mem yet.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_count == CNTW'(1)) begin
                if (w_do_push) begin
                    w_head_next = w_push_word;
                end
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end else if (r_count == '0 && w_do_push) begin
            w_head_next = w_push_word;
        end
    end

    // NOTE: the storage array has no reset. The pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge CLOCK_50) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_head  <= w_head_next;
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign sample_data  = r_head[DATA_BITS-1:0];
    assign sample_chan  = r_head[EW-1:DATA_BITS];
    assign sample_valid = r_valid;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

SPI master and sample buffer for the on-board 8-channel 12-bit serial ADC. It sits between the ADC pins (SPI_SS, SPI_CLOCK, SPI_MOSI, SPI_MISO) and the NIOS II peripheral side. It runs single or free-running conversion frames and queues the tagged results in a small show-ahead FIFO, which the processor drains with a valid/ready handshake.

## Interface
Parameters:
- CLK_DIV, 4: CLOCK_50 cycles per SPI_CLOCK half-period (≥2).
- FRAME_BITS, 16: SPI clocks per frame.
- DATA_BITS, 12: result width, taken from the last DATA_BITS bits received.
- FIFO_DEPTH, 8: sample FIFO entries (power of 2).

Ports (one clock; reset is synchronous and active-low):
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- start  in  1  one-cycle request for a single frame on `channel`.
- auto_en  in  1  free-running scan: channels step 0→7→0…
- channel  in  3  channel for `start`.
- ovf_clr  in  1  clears `overflow`.
- SPI_MISO  in  1  ADC serial data out.
- SPI_MOSI  out  1  control word to ADC.
- SPI_CLOCK  out  1  serial clock, idle high.
- SPI_SS  out  1  chip select, active low.
- sample_data  out  DATA_BITS  FIFO head result.
- sample_chan  out  3  FIFO head channel tag.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer pop.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupancy.
- busy  out  1  frame or gap in progress.
- overflow  out  1  sticky: sample dropped because FIFO full.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - `start` is taken first and latches `channel`.
  - Otherwise `auto_en` starts a frame on channel 0, or on the channel after the last auto frame.
  - Transition to SETUP.
- SETUP: SS=0, SCLK=1, MOSI = control bit FRAME_BITS-1; lasts CLK_DIV cycles.
- SHIFT: FRAME_BITS periods, each CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
  - MOSI changes on each SCLK falling edge, except bit FRAME_BITS-1, which is driven in SETUP.
  - MISO is sampled into the shift register on the cycle SCLK rises.
- Control word: bits 13:11 = latched channel; all other bits 0.
- HOLD: SS=0, SCLK=1 for CLK_DIV cycles. On exit, SS=1 and the result plus channel are pushed to the FIFO.
- GAP: SS=1 for CLK_DIV cycles, then IDLE.
- Auto scan: if `auto_en` is still high at the end of GAP, the next frame starts with channel+1 mod 8.
- `busy` = state ≠ IDLE. `start` while busy is ignored (not queued).
- FIFO:
  - Show-ahead: sample_data and sample_chan always present the head entry.
  - Pop when sample_valid && sample_ready.
  - Push while full: the sample is dropped and `overflow` is set. Exception: if a pop occurs in the same cycle, both happen and the count is unchanged.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- `ovf_clr` clears `overflow`. If a drop occurs in the same cycle, set wins.
- Reset (any time, including mid-frame): state IDLE, SPI_SS=1, SPI_CLOCK=1, SPI_MOSI=0, FIFO emptied, sample_valid=0, fifo_count=0, busy=0, overflow=0, auto channel=0, sample_data=0, sample_chan=0. A partial frame is discarded.

## Timing
- All outputs are registered.
- With `start` sampled at edge k:
  - SPI_SS falls at k+1.
  - First SCLK fall at k+1+CLK_DIV.
  - SPI_SS rises and FIFO push at k+1+CLK_DIV+2·CLK_DIV·FRAME_BITS+CLK_DIV. For defaults, that is k+137.
- sample_valid rises at the same edge as SPI_SS when the FIFO was empty.
- busy falls CLK_DIV cycles after SS rises (k+141 by default).
- Auto mode back-to-back SS-high time is CLK_DIV+1 cycles; the extra cycle is the IDLE cycle.
- SCLK period = 2·CLK_DIV cycles (6.25 MHz at defaults).
- Pop is visible next cycle: the new head appears, or sample_valid falls.

## Test plan
- Single frame:
  - Stimulus: `start`, channel=5; ADC model returns 0x0ABC on MISO (MSB first, sampled on SCLK rise).
  - Response: MOSI word 0x2800; exactly 16 SCLK rises; SS low for 136 cycles; sample_data=0xABC, sample_chan=5, fifo_count=1.
- Handshake:
  - Stimulus: hold sample_ready=0 for 3 frames, then assert it for 1 cycle.
  - Response: fifo_count 3→2; head advances to the second sample.
- Overflow:
  - Stimulus: auto_en=1 with ready=0 for 10 frames.
  - Response: fifo_count saturates at 8 holding channels 0..7; overflow=1. Then ovf_clr gives overflow=0 next cycle.
- Full with simultaneous push and pop:
  - Stimulus: assert ready exactly on the push edge while full.
  - Response: count stays 8, overflow stays 0, the new sample is at the tail.
- Reset mid-frame:
  - Stimulus: RESET_N=0 during bit 7 of SHIFT.
  - Response: next edge SS=1, SCLK=1, MOSI=0, fifo_count=0, busy=0. After release, a new `start` produces a clean full frame.
- Busy rejection:
  - Stimulus: pulse `start` at k+50 during a frame.
  - Response: it is ignored; exactly one sample is pushed.
